msg_bridge: RTL and testbench

MSG_BRIDGE -- requirements
Module: msg_bridge

---
 rtl/msg_bridge_pkg.sv | 26 ++
 rtl/msg_bridge_if.sv | 35 +++
 rtl/msg_fifo.sv | 47 ++++
 rtl/msg_bridge.sv | 182 ++++++++++++++++++
 tb/tb_msg_bridge.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/msg_bridge_pkg.sv
// Shared types, status codes and message field layout for the UART <-> cell message bridge.
package msg_bridge_pkg;

  // Status code that marks an idle or empty message; such messages are never queued.
  localparam logic [3:0] IDLE_STATUS = 4'hF;

  // Message layout, LSB first: status[3:0], 1'b0, j, 1'b0, i.
  localparam int unsigned STATUS_LSB = 0;
  localparam int unsigned STATUS_W   = 4;
  localparam int unsigned J_LSB      = 5;

  function automatic int unsigned msg_width(input int unsigned addr_width);
    return 2 * (addr_width + 1) + 4;
  endfunction

  function automatic int unsigned i_lsb(input int unsigned addr_width);
    return addr_width + 6;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } ser_state_e;

endpackage

// File: rtl/msg_bridge_if.sv
// Bundle of the UART-side byte strobes and the cell-side message handshakes.
interface msg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  import msg_bridge_pkg::*;

  localparam int unsigned MESSAGE_WIDTH = msg_width(ADDR_WIDTH);

  logic [7:0]               rxdata;
  logic                     rxfinish;
  logic [7:0]               txdata;
  logic                     send;
  logic                     txdone;
  logic [MESSAGE_WIDTH-1:0] rxmessage;
  logic                     rxvalid;
  logic                     rxready;
  logic [MESSAGE_WIDTH-1:0] txmessage;
  logic                     txvalid;
  logic                     txready;
  logic                     rx_overflow;
  logic [7:0]               drop_cnt;

  // Environment side: UART model and cell array.
  modport master (
    output rxdata, rxfinish, txdone, rxready, txmessage, txvalid,
    input  txdata, send, rxmessage, rxvalid, txready, rx_overflow, drop_cnt
  );

  // Bridge side.
  modport slave (
    input  rxdata, rxfinish, txdone, rxready, txmessage, txvalid,
    output txdata, send, rxmessage, rxvalid, txready, rx_overflow, drop_cnt
  );

endinterface

// File: rtl/msg_fifo.sv
// Show-ahead FIFO; a push while full is accepted only when a pop frees the slot on the same edge.
module msg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Pointer compare with a wrap bit distinguishes full from empty.
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  // Read/write pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/msg_bridge.sv
// Bridges 3-byte UART frames to cell messages (RX) and serialises cell messages to bytes (TX).
module msg_bridge import msg_bridge_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input logic         clk,
  input logic         rst,
  msg_bridge_if.slave bus
);

  localparam int unsigned MW  = msg_width(ADDR_WIDTH);
  localparam int unsigned ILsb = i_lsb(ADDR_WIDTH);
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // RX assembler state
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, j_q, j_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;
  logic                  drop_evt, rx_push, rx_pop, rx_full, rx_empty;
  logic [MW-1:0]         rx_frame;

  // TX serializer state
  ser_state_e state_q, state_d;
  logic [1:0] byte_q, byte_d, sel_byte;
  logic [7:0] txdata_q, txdata_d, sel_data;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [MW-1:0] tx_head;

  logic unused_bits;
  assign unused_bits = ^{bus.rxdata, tx_head};

  // RX: collect bytes, filter idle/overflow frames and discard stale partial frames.
  always_comb begin
    idx_d    = idx_q;
    i_d      = i_q;
    j_d      = j_q;
    tmo_d    = tmo_q;
    ovf_d    = ovf_q;
    drop_evt = 1'b0;
    rx_push  = 1'b0;
    rx_pop   = bus.rxvalid && bus.rxready;
    rx_frame = {i_q, 1'b0, j_q, 1'b0, bus.rxdata[3:0]};
    if (bus.rxfinish) begin
      tmo_d = '0;
      case (idx_q)
        2'd0: begin i_d = bus.rxdata[ADDR_WIDTH-1:0]; idx_d = 2'd1; end
        2'd1: begin j_d = bus.rxdata[ADDR_WIDTH-1:0]; idx_d = 2'd2; end
        default: begin
          idx_d = 2'd0;
          if (bus.rxdata[3:0] == IDLE_STATUS) begin
            drop_evt = 1'b1;
          end else if (rx_full && !rx_pop) begin
            drop_evt = 1'b1;
            ovf_d    = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end
      endcase
    end else if (TIMEOUT != 0 && idx_q != 2'd0) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        idx_d    = 2'd0;
        tmo_d    = '0;
        drop_evt = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
    drop_d = (drop_evt && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  // RX assembler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= 2'd0;
      i_q    <= '0;
      j_q    <= '0;
      tmo_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      idx_q  <= idx_d;
      i_q    <= i_d;
      j_q    <= j_d;
      tmo_q  <= tmo_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  msg_fifo #(.WIDTH(MW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rx_push),
    .wdata_i (rx_frame),
    .pop_i   (rx_pop),
    .rdata_o (bus.rxmessage),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  msg_fifo #(.WIDTH(MW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tx_push),
    .wdata_i (bus.txmessage),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // Handshake outputs; txready is held low while in reset.
  always_comb begin
    bus.rxvalid     = !rx_empty;
    bus.rx_overflow = ovf_q;
    bus.drop_cnt    = drop_q;
    bus.txready     = !rst && !tx_full;
    tx_push         = bus.txvalid && bus.txready && (bus.txmessage[3:0] != IDLE_STATUS);
    bus.send        = (state_q == StSend);
    bus.txdata      = txdata_q;
  end

  // Byte of the head message to load on the next entry into SEND.
  always_comb begin
    sel_byte = (state_q == StWait) ? byte_q + 2'd1 : 2'd0;
    case (sel_byte)
      2'd0:    sel_data = 8'(tx_head[ILsb +: ADDR_WIDTH]);
      2'd1:    sel_data = 8'(tx_head[J_LSB +: ADDR_WIDTH]);
      default: sel_data = {4'b0, tx_head[STATUS_LSB +: STATUS_W]};
    endcase
  end

  // Serializer next state: one send strobe per byte, pop only after the last txdone.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    txdata_d = txdata_q;
    tx_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_empty) begin
          state_d  = StSend;
          byte_d   = 2'd0;
          txdata_d = sel_data;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (bus.txdone) begin
          if (byte_q != 2'd2) begin
            byte_d   = sel_byte;
            txdata_d = sel_data;
            state_d  = StSend;
          end else begin
            tx_pop  = 1'b1;
            byte_d  = 2'd0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Serializer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      byte_q   <= 2'd0;
      txdata_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      txdata_q <= txdata_d;
    end
  end

endmodule

// File: tb/tb_msg_bridge.sv
// Scoreboard bench for msg_bridge: stimulus pushes expectations, monitors pop and compare.
module tb_msg_bridge;

  localparam int unsigned AW  = 4;
  localparam int unsigned DEP = 4;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  msg_bridge #(.ADDR_WIDTH(AW), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [13:0] rx_exp_q [$];
  logic [7:0]  tx_exp_q [$];
  bit          resp_en = 1'b1;
  logic [7:0]  resp_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic [3:0] i, input logic [3:0] j,
                                     input logic [3:0] s);
    return {i, 1'b0, j, 1'b0, s};
  endfunction

  // Monitors: compare every consumed RX message and every send strobe against the queues.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.rxvalid && bus.rxready) begin
      if (rx_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rx_unexpected actual=%0h required=none", bus.rxmessage);
      end else check("rx_msg", 32'(bus.rxmessage), 32'(rx_exp_q.pop_front()));
    end
    if (bus.send) begin
      if (tx_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected actual=%0h required=none", bus.txdata);
      end else check("tx_byte", 32'(bus.txdata), 32'(tx_exp_q.pop_front()));
    end
  end

  // UART transmitter model: answers each send with a delayed txdone, checking txdata holds.
  initial begin
    bus.txdone = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.send && resp_en) begin
        resp_byte = bus.txdata;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tx_hold", 32'(bus.txdata), 32'(resp_byte));
        @(posedge clk); #1 bus.txdone = 1'b1;
        @(posedge clk); #1 bus.txdone = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    bus.rxready = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rxdata   = b;
    bus.rxfinish = 1'b1;
    @(posedge clk); #1 bus.rxfinish = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input int gap);
    rx_byte(a); idle(gap); rx_byte(b); idle(gap); rx_byte(c);
  endtask

  task automatic tx_send(input logic [13:0] m);
    int n = 0;
    bus.txmessage = m;
    bus.txvalid   = 1'b1;
    while (!bus.txready && n < 100) begin @(posedge clk); #1; n++; end
    if (n == 100) begin checks++; failures++; $display("FAIL tx_accept_timeout"); end
    @(posedge clk); #1 bus.txvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    idle(10);
    check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.rxdata = 8'd0; bus.rxfinish = 1'b0; bus.rxready = 1'b0;
    bus.txmessage = '0; bus.txvalid = 1'b0;
    idle(1);
    // Values while reset is held
    check("rst_txdata", 32'(bus.txdata), 32'd0);
    check("rst_send", 32'(bus.send), 32'd0);
    check("rst_rxvalid", 32'(bus.rxvalid), 32'd0);
    check("rst_txready", 32'(bus.txready), 32'd0);
    check("rst_overflow", 32'(bus.rx_overflow), 32'd0);
    check("rst_drop", 32'(bus.drop_cnt), 32'd0);
    check("rst_rxmessage", 32'(bus.rxmessage), 32'd0);
    rst = 1'b0;
    idle(1);
    check("txready_after_rst", 32'(bus.txready), 32'd1);

    // Basic RX frame, rxvalid the cycle after the third byte
    rx_exp_q.push_back(mk(4'h3, 4'h5, 4'h2));
    rx_byte(8'h03); idle(1); rx_byte(8'h05); idle(1);
    check("rxvalid_before_byte2", 32'(bus.rxvalid), 32'd0);
    rx_byte(8'h02);
    check("rxvalid_after_byte2", 32'(bus.rxvalid), 32'd1);
    bus.rxready = 1'b1;
    // Upper bits of each byte ignored
    rx_exp_q.push_back(mk(4'h7, 4'h1, 4'h9));
    rx_frame(8'hA7, 8'hF1, 8'h39, 1);
    wait_drain();
    check("rxvalid_empty", 32'(bus.rxvalid), 32'd0);

    // TX: four queued messages fill the FIFO; idle-status message is swallowed
    tx_exp_q.push_back(8'h01); tx_exp_q.push_back(8'h02); tx_exp_q.push_back(8'h06);
    tx_send(mk(4'h1, 4'h2, 4'h6));
    tx_send(mk(4'h3, 4'h3, 4'hF));
    tx_exp_q.push_back(8'h0F); tx_exp_q.push_back(8'h09); tx_exp_q.push_back(8'h00);
    tx_send(mk(4'hF, 4'h9, 4'h0));
    tx_exp_q.push_back(8'h04); tx_exp_q.push_back(8'h05); tx_exp_q.push_back(8'h01);
    tx_send(mk(4'h4, 4'h5, 4'h1));
    tx_exp_q.push_back(8'h02); tx_exp_q.push_back(8'h07); tx_exp_q.push_back(8'h03);
    tx_send(mk(4'h2, 4'h7, 4'h3));
    check("txready_full", 32'(bus.txready), 32'd0);
    wait_drain();
    check("txready_drained", 32'(bus.txready), 32'd1);

    // Idle-status RX frame is dropped
    do_reset();
    rx_frame(8'h01, 8'h02, 8'h0F, 1);
    idle(2);
    check("idle_frame_rxvalid", 32'(bus.rxvalid), 32'd0);
    check("idle_frame_drop", 32'(bus.drop_cnt), 32'd1);

    // Overflow: five frames into a four-deep FIFO with no consumer
    do_reset();
    check("overflow_cleared", 32'(bus.rx_overflow), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) rx_exp_q.push_back(mk(4'(k), 4'(k), 4'(k)));
      rx_frame(8'(k), 8'(k), 8'(k), 0);
    end
    check("ovf_flag", 32'(bus.rx_overflow), 32'd1);
    check("ovf_drop", 32'(bus.drop_cnt), 32'd1);
    bus.rxready = 1'b1;
    wait_drain();
    check("ovf_sticky", 32'(bus.rx_overflow), 32'd1);

    // Full FIFO with a pop on the completing edge accepts the frame
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      rx_exp_q.push_back(mk(4'(k), 4'(k), 4'(k)));
      rx_frame(8'(k), 8'(k), 8'(k), 0);
    end
    rx_exp_q.push_back(mk(4'h6, 4'h7, 4'h5));
    rx_byte(8'h06); rx_byte(8'h07);
    bus.rxdata = 8'h05; bus.rxfinish = 1'b1; bus.rxready = 1'b1;
    @(posedge clk); #1 bus.rxfinish = 1'b0; bus.rxready = 1'b0;
    check("fullpop_ovf", 32'(bus.rx_overflow), 32'd0);
    check("fullpop_drop", 32'(bus.drop_cnt), 32'd0);
    bus.rxready = 1'b1;
    wait_drain();

    // Timeout discards a partial frame after exactly TMO idle cycles
    do_reset();
    bus.rxready = 1'b1;
    rx_byte(8'h0A); rx_byte(8'h0B);
    idle(TMO - 1);
    check("tmo_not_yet", 32'(bus.drop_cnt), 32'd0);
    idle(1);
    check("tmo_drop", 32'(bus.drop_cnt), 32'd1);
    rx_exp_q.push_back(mk(4'h3, 4'h4, 4'h5));
    rx_frame(8'h03, 8'h04, 8'h05, 2);
    wait_drain();

    // Reset while the serializer waits for txdone, with a partial RX frame pending
    do_reset();
    resp_en = 1'b0;
    tx_exp_q.push_back(8'h01);
    tx_send(mk(4'h1, 4'h2, 4'h6));
    rx_byte(8'h09); rx_byte(8'h09);
    idle(2);
    rst = 1'b1;
    idle(2);
    check("wait_rst_send", 32'(bus.send), 32'd0);
    check("wait_rst_txready", 32'(bus.txready), 32'd0);
    rst = 1'b0;
    resp_en = 1'b1;
    idle(20);
    check("wait_rst_txready_after", 32'(bus.txready), 32'd1);
    check("wait_rst_first_byte_seen", 32'(tx_exp_q.size()), 32'd0);
    bus.rxready = 1'b1;
    rx_exp_q.push_back(mk(4'h1, 4'h4, 4'h5));
    rx_frame(8'h01, 8'h04, 8'h05, 0);
    wait_drain();

    // drop_cnt saturates
    do_reset();
    for (int k = 0; k < 255; k++) rx_frame(8'h00, 8'h00, 8'h0F, 0);
    idle(1);
    check("drop_255", 32'(bus.drop_cnt), 32'hFF);
    rx_frame(8'h00, 8'h00, 8'h0F, 0);
    idle(1);
    check("drop_saturate", 32'(bus.drop_cnt), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
